// File: rtl/hack_mem_pkg.sv
// hack_mem_pkg: shared widths and word type for the Hack memory hierarchy
package hack_mem_pkg;
  localparam int WORD_W = 16;
  localparam int RAM8_ADDR_W = 3;
  localparam int BANK_SEL_W = 3;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/ram64_ram8.sv
// ram8: eight async-clear registers with a load demux and an 8:1 combinational read mux
module ram8
  import hack_mem_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in,
  input  logic                   load,
  input  logic [RAM8_ADDR_W-1:0] address,
  output logic [WIDTH-1:0]       out
);
  logic [WIDTH-1:0] mem [2**RAM8_ADDR_W];
  logic [2**RAM8_ADDR_W-1:0] sel;
  always_comb sel = load ? (2**RAM8_ADDR_W)'(1) << address : '0;
  for (genvar w = 0; w < 2**RAM8_ADDR_W; w++) begin : g_word
    always_ff @(posedge clk or posedge reset)
      if (reset) mem[w] <= '0;
      else if (sel[w]) mem[w] <= in;
  end
  assign out = mem[address];
endmodule

// File: rtl/ram64.sv
// ram64: 64x16 RAM built from eight ram8 banks; combinational read, clocked write, async clear
module ram64
  import hack_mem_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int ADDR_W = RAM8_ADDR_W + BANK_SEL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  output logic [WIDTH-1:0]  out
);
  logic [BANK_SEL_W-1:0] bank;
  logic [2**BANK_SEL_W-1:0] bank_load;
  logic [WIDTH-1:0] bank_out [2**BANK_SEL_W];
  assign bank = address[ADDR_W-1 -: BANK_SEL_W];
  always_comb bank_load = load ? (2**BANK_SEL_W)'(1) << bank : '0;
  for (genvar b = 0; b < 2**BANK_SEL_W; b++) begin : g_bank
    ram8 #(.WIDTH(WIDTH)) u_ram8 (
      .clk    (clk),
      .reset  (reset),
      .in     (in),
      .load   (bank_load[b]),
      .address(address[RAM8_ADDR_W-1:0]),
      .out    (bank_out[b])
    );
  end
  assign out = bank_out[bank];
endmodule

// File: tb/tb_ram64.sv
// tb_ram64: directed self-checking bench for ram64
module tb_ram64;
  logic clk = 0;
  logic reset = 1;
  logic [15:0] in = '0;
  logic load = 0;
  logic [5:0] address = '0;
  logic [15:0] out;
  int checks = 0;
  int failures = 0;

  ram64 dut (
    .clk    (clk),
    .reset  (reset),
    .in     (in),
    .load   (load),
    .address(address),
    .out    (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [5:0] a, input logic [15:0] exp);
    address = a;
    #1;
    chk(tag, out, exp);
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    address = a;
    in = d;
    load = 1;
    tick();
    load = 0;
  endtask

  initial begin
    #2;
    chk("reset_init", out, 16'h0000);
    tick();
    reset = 0;
    // 1: reset clears immediately, mid-cycle
    wr(6'd5, 16'h1234);
    rd("pre_reset", 6'd5, 16'h1234);
    #2;
    reset = 1;
    #1;
    chk("reset_async", out, 16'h0000);
    for (int a = 0; a < 64; a++) rd("reset_sweep", 6'(a), 16'h0000);
    reset = 0;
    tick();
    // 2: single write
    wr(6'd42, 16'hBEEF);
    rd("wr42", 6'd42, 16'hBEEF);
    rd("iso41", 6'd41, 16'h0000);
    rd("iso43", 6'd43, 16'h0000);
    rd("iso2", 6'd2, 16'h0000);
    rd("iso58", 6'd58, 16'h0000);
    // 3: fill and sweep
    for (int a = 0; a < 64; a++) wr(6'(a), 16'(a + 1));
    for (int a = 0; a < 64; a++) rd("fill_sweep", 6'(a), 16'(a + 1));
    rd("bank_edge7", 6'd7, 16'h0008);
    rd("bank_edge8", 6'd8, 16'h0009);
    // 4: read-during-write shows old value until the edge
    wr(6'd10, 16'h00AA);
    address = 6'd10;
    in = 16'h5555;
    load = 1;
    #1;
    chk("rdw_before", out, 16'h00AA);
    tick();
    load = 0;
    chk("rdw_after", out, 16'h5555);
    // 5: hold with load low
    wr(6'd3, 16'h0C0C);
    address = 6'd3;
    in = 16'hFFFF;
    for (int i = 0; i < 5; i++) tick();
    chk("hold", out, 16'h0C0C);
    rd("hold_nb", 6'd4, 16'h0005);
    // 6: writes ignored under reset
    reset = 1;
    address = 6'd63;
    in = 16'hCAFE;
    load = 1;
    tick();
    tick();
    reset = 0;
    #1;
    chk("wr_under_reset", out, 16'h0000);
    tick();
    load = 0;
    chk("wr_after_release", out, 16'hCAFE);
    rd("post_release_other", 6'd62, 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram64.md
Name: ram64

Overview:
- 64-word × 16-bit random-access memory for the sequential-chip layer.
- Sits directly downstream of the DFF stage: every storage bit is a registered flip-flop, organised as eight ram8 banks.
- Serves as the building block for the larger RAM512/RAM4K stages.
- Combinational read, clocked write, Hack memory semantics, plus an asynchronous clear.

Parameters:
- WIDTH, 16: data word width in bits.
- ADDR_W, 6: address width; depth = 2**ADDR_W = 64 words; fixed at 6 for this block.

Ports:
- clk  input  1  rising-edge clock for all storage.
- reset  input  1  asynchronous, active-high clear of every word.
- in  input  WIDTH  write data.
- load  input  1  write enable, sampled on the rising edge of clk.
- address  input  ADDR_W  word select; address[5:3] = bank, address[2:0] = word within bank.
- out  output  WIDTH  contents of the word at address.

Behaviour:
- Storage: 64 registers of WIDTH bits, each built as WIDTH DFF-style flops with a load mux (Bit/Register semantics).
- Reset:
  - reset=1 clears all 64 words to 0 immediately, with no clock edge required.
  - out reads 0 for every address while reset is high.
  - Writes are ignored while reset is high, even with load=1 on a clock edge.
- Write:
  - On posedge clk with reset=0 and load=1, word[address] <= in.
  - Exactly one word changes; the other 63 hold.
- Hold: on posedge clk with load=0, no word changes.
- Read:
  - out = word[address], purely combinational.
  - A change on address updates out within the same cycle, with zero clock latency.
- Read-during-write, same address:
  - Before the edge, out shows the old value.
  - After the edge, out shows the new value.
  - in never bypasses to out.
- Decode:
  - load is routed only to the bank selected by address[5:3] (DMux8Way equivalent).
  - Within that bank, load is routed only to the word selected by address[2:0].
  - out is an 8-way mux over the bank outputs using address[5:3].
- Reset released mid-cycle: the first write is taken at the first rising edge after reset falls.
- Address changes are valid at any time; only the value present at the edge determines the write target.
- No X propagation after reset: every word has a defined value of 0.

Decomposition:
- Shared package hack_mem_pkg:
  - WORD_W = 16.
  - RAM8_ADDR_W = 3.
  - BANK_SEL_W = 3.
  - Word type for WIDTH-bit data.
- Sub-module ram8:
  - Same port set, with a 3-bit address.
  - Contains eight WIDTH-bit registers, the load demux and the 8:1 read mux.
- ram64 instantiates eight ram8 banks plus the top-level bank demux and mux.
- ram8 is reused unchanged by future RAM512/RAM4K stages.

Test Plan:
1. Reset clear: write 0x1234 to address 5, then pulse reset between clock edges → out reads 0x0000 immediately; a sweep of addresses 0..63 reads 0 everywhere.
2. Write/read: load=1, in=0xBEEF, address=42 (bank 5, word 2), one edge; then load=0 → out=0xBEEF at address 42, 0x0000 at addresses 41, 43, 2 and 58.
3. Bank isolation: write 0x0001..0x0040 to addresses 0..63 in turn → a readback sweep returns word[a]=a+1 for every address; address 7 reads 0x0008 and address 8 reads 0x0009 across the bank boundary.
4. Read-during-write: address 10 holds 0x00AA; set in=0x5555, load=1 → out stays 0x00AA until posedge, then becomes 0x5555 on the same address.
5. Load low hold: load=0, in=0xFFFF, clocked for 5 edges at address 3 (holding 0x0C0C) → out remains 0x0C0C.
6. Write under reset: reset=1, load=1, in=0xCAFE, address=63, two edges; release reset → address 63 reads 0x0000; the next edge with load=1 writes 0xCAFE and it reads back.
